// File: rtl/sine_phase_acc.sv
// Phase-accumulator address generator for a 256x8 sine ROM: two phase-offset
// addresses, a wrap pulse and a ROM-latency-aligned data-valid flag.
module sine_phase_acc #(
    parameter int ACC_W   = 16,
    parameter int ADDR_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              single,
    input  logic              stop,
    input  logic              en,
    input  logic [ACC_W-1:0]  step,
    input  logic [ADDR_W-1:0] offset,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr2,
    output logic              busy,
    output logic              wrap,
    output logic              addr_vld,
    output logic              dout_vld
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   step_q, step_d;
    logic               single_q, single_d;
    logic               wrap_q, wrap_d;
    logic [ROM_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic [ACC_W:0]     sum_s;

    assign sum_s    = {1'b0, acc_q} + {1'b0, step_q};
    assign addr     = acc_q[ACC_W-1 -: ADDR_W];
    assign addr2    = addr + offset;
    assign busy     = (state_q == RUN);
    assign wrap     = wrap_q;
    assign addr_vld = busy & en;
    assign dout_vld = vld_pipe_q[ROM_LAT-1];

    // Next-state and accumulator update; stop outranks advance and discards a same-cycle carry.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        step_d   = step_q;
        single_d = single_q;
        wrap_d   = 1'b0;
        case (state_q)
            IDLE: begin
                acc_d = {ACC_W{1'b0}};
                if (start && !stop) begin
                    step_d   = step;
                    single_d = single;
                    state_d  = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    acc_d   = {ACC_W{1'b0}};
                    state_d = IDLE;
                end else if (en) begin
                    acc_d = sum_s[ACC_W-1:0];
                    // New step is only picked up at a period boundary so phase stays continuous.
                    if (sum_s[ACC_W]) begin
                        wrap_d = 1'b1;
                        step_d = step;
                        if (single_q) begin
                            acc_d   = {ACC_W{1'b0}};
                            state_d = IDLE;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        wrap_d = 1'b0;
                    end
                end else begin
                    acc_d = acc_q;
                end
            end
            default: begin
                acc_d   = {ACC_W{1'b0}};
                state_d = IDLE;
            end
        endcase
    end

    // Shift addr_vld through ROM_LAT stages to line up with ROM output data.
    always_comb begin
        vld_pipe_d    = vld_pipe_q;
        vld_pipe_d[0] = addr_vld;
        for (int i = 1; i < ROM_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
    end

    // State, accumulator, latched controls and valid pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= {ACC_W{1'b0}};
            step_q     <= {ACC_W{1'b0}};
            single_q   <= 1'b0;
            wrap_q     <= 1'b0;
            vld_pipe_q <= {ROM_LAT{1'b0}};
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
            single_q   <= single_d;
            wrap_q     <= wrap_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

endmodule

// File: tb/tb_sine_phase_acc.sv
// Directed self-checking bench for sine_phase_acc with hand-computed expectations.
module tb_sine_phase_acc;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        single;
    logic        stop;
    logic        en;
    logic [15:0] step;
    logic [7:0]  offset;
    logic [7:0]  addr;
    logic [7:0]  addr2;
    logic        busy;
    logic        wrap;
    logic        addr_vld;
    logic        dout_vld;

    int checks = 0;
    int errors = 0;

    sine_phase_acc #(.ACC_W(16), .ADDR_W(8), .ROM_LAT(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .single   (single),
        .stop     (stop),
        .en       (en),
        .step     (step),
        .offset   (offset),
        .addr     (addr),
        .addr2    (addr2),
        .busy     (busy),
        .wrap     (wrap),
        .addr_vld (addr_vld),
        .dout_vld (dout_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Stop the generator from RUN and leave all controls idle.
    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        single = 1'b0;
        stop   = 1'b0;
        en     = 1'b0;
        step   = 16'h0000;
        offset = 8'h12;
        #12;
        chk("rst_addr",  {24'd0, addr},     32'h00);
        chk("rst_addr2", {24'd0, addr2},    32'h12);
        chk("rst_busy",  {31'd0, busy},     32'h0);
        chk("rst_dvld",  {31'd0, dout_vld}, 32'h0);
        rst_n  = 1'b1;
        offset = 8'h00;
        tick();

        // Test 1: full period with step 0x0100.
        step  = 16'h0100;
        en    = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy",  {31'd0, busy},     32'h1);
        chk("t1_addr0", {24'd0, addr},     32'h00);
        chk("t1_avld",  {31'd0, addr_vld}, 32'h1);
        chk("t1_dvld0", {31'd0, dout_vld}, 32'h0);
        for (int k = 1; k < 256; k++) begin
            tick();
            chk("t1_addr", {24'd0, addr}, k);
            chk("t1_wrap", {31'd0, wrap}, 32'h0);
            if (k == 1) chk("t1_dvld1", {31'd0, dout_vld}, 32'h1);
        end
        tick();
        chk("t1_addr256", {24'd0, addr}, 32'h00);
        chk("t1_wrap256", {31'd0, wrap}, 32'h1);
        tick();
        chk("t1_addr257", {24'd0, addr}, 32'h01);
        chk("t1_wrap257", {31'd0, wrap}, 32'h0);
        do_stop();
        chk("t1_stop_busy", {31'd0, busy}, 32'h0);
        chk("t1_stop_addr", {24'd0, addr}, 32'h00);

        // Test 2: single period with step 0x4000.
        step   = 16'h4000;
        single = 1'b1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        single = 1'b0;
        chk("t2_addr0", {24'd0, addr}, 32'h00);
        tick(); chk("t2_addr1", {24'd0, addr}, 32'h40);
        tick(); chk("t2_addr2", {24'd0, addr}, 32'h80);
        tick(); chk("t2_addr3", {24'd0, addr}, 32'hC0);
        chk("t2_busy3", {31'd0, busy}, 32'h1);
        tick();
        chk("t2_wrap",  {31'd0, wrap},     32'h1);
        chk("t2_busy",  {31'd0, busy},     32'h0);
        chk("t2_addr",  {24'd0, addr},     32'h00);
        chk("t2_avld",  {31'd0, addr_vld}, 32'h0);
        chk("t2_dvld",  {31'd0, dout_vld}, 32'h1);
        tick();
        chk("t2_idle_wrap", {31'd0, wrap}, 32'h0);
        chk("t2_idle_busy", {31'd0, busy}, 32'h0);
        tick();
        chk("t2_idle_addr", {24'd0, addr}, 32'h00);

        // Test 3: live offset on addr2 with step 0x2000.
        step   = 16'h2000;
        offset = 8'h40;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k != 0) tick();
            chk("t3_addr",  {24'd0, addr},  (k * 32'h20) & 32'hFF);
            chk("t3_addr2", {24'd0, addr2}, (k * 32'h20 + 32'h40) & 32'hFF);
        end
        chk("t3_e0_addr2", {24'd0, addr2}, 32'h20);
        offset = 8'h05;
        #1;
        chk("t3_live_off", {24'd0, addr2}, 32'hE5);
        offset = 8'h00;
        do_stop();

        // Test 4: pause at 0x37 for three cycles.
        step  = 16'h0100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16'h37; k++) tick();
        chk("t4_addr37", {24'd0, addr}, 32'h37);
        en = 1'b0;
        #1;
        chk("t4_p1_addr", {24'd0, addr},     32'h37);
        chk("t4_p1_avld", {31'd0, addr_vld}, 32'h0);
        chk("t4_p1_dvld", {31'd0, dout_vld}, 32'h1);
        tick();
        chk("t4_p2_addr", {24'd0, addr},     32'h37);
        chk("t4_p2_avld", {31'd0, addr_vld}, 32'h0);
        chk("t4_p2_dvld", {31'd0, dout_vld}, 32'h0);
        tick();
        chk("t4_p3_addr", {24'd0, addr},     32'h37);
        chk("t4_p3_dvld", {31'd0, dout_vld}, 32'h0);
        en = 1'b1;
        #1;
        chk("t4_r_avld", {31'd0, addr_vld}, 32'h1);
        chk("t4_r_dvld", {31'd0, dout_vld}, 32'h0);
        tick();
        chk("t4_r_addr",  {24'd0, addr},     32'h38);
        chk("t4_r_dvld2", {31'd0, dout_vld}, 32'h1);
        do_stop();

        // Test 5: step change mid-period takes effect after wrap.
        step  = 16'h0100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) tick();
        chk("t5_addr10", {24'd0, addr}, 32'h10);
        step = 16'h0200;
        tick();
        chk("t5_addr11", {24'd0, addr}, 32'h11);
        for (int k = 0; k < 8'hEE; k++) tick();
        chk("t5_addrFF", {24'd0, addr}, 32'hFF);
        tick();
        chk("t5_wrap",  {31'd0, wrap}, 32'h1);
        chk("t5_addr0", {24'd0, addr}, 32'h00);
        tick(); chk("t5_addr2", {24'd0, addr}, 32'h02);
        tick(); chk("t5_addr4", {24'd0, addr}, 32'h04);
        do_stop();

        // Stop coincident with carry: no wrap pulse.
        step  = 16'h8000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("sc_addr80", {24'd0, addr}, 32'h80);
        do_stop();
        chk("sc_wrap", {31'd0, wrap}, 32'h0);
        chk("sc_busy", {31'd0, busy}, 32'h0);

        // step=0: address frozen, no wrap.
        step  = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s0_addr", {24'd0, addr}, 32'h00);
            chk("s0_wrap", {31'd0, wrap}, 32'h0);
            chk("s0_busy", {31'd0, busy}, 32'h1);
        end

        // Test 6: stop and start together in RUN, then in IDLE.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        chk("t6_run_busy", {31'd0, busy}, 32'h0);
        chk("t6_run_addr", {24'd0, addr}, 32'h00);
        tick();
        chk("t6_idle_busy", {31'd0, busy}, 32'h0);
        start = 1'b0;
        stop  = 1'b0;

        // Asynchronous reset mid-run.
        step   = 16'h0100;
        offset = 8'h33;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        chk("t6_pre_addr", {24'd0, addr}, 32'h02);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_addr",  {24'd0, addr},     32'h00);
        chk("t6_rst_addr2", {24'd0, addr2},    32'h33);
        chk("t6_rst_busy",  {31'd0, busy},     32'h0);
        chk("t6_rst_wrap",  {31'd0, wrap},     32'h0);
        chk("t6_rst_avld",  {31'd0, addr_vld}, 32'h0);
        chk("t6_rst_dvld",  {31'd0, dout_vld}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_post_busy", {31'd0, busy}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
